alu_op_scheduler: RTL and testbench

ALU_OP_SCHEDULER -- requirements
Module: alu_op_scheduler

---
 rtl/alu_op_scheduler_pkg.sv | 66 ++++++
 rtl/alu_op_scheduler_arbiter.sv | 42 ++++
 rtl/alu_op_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_alu_op_scheduler.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// alu_op_scheduler_pkg
// Shared definitions for the ALU operation scheduler and the shared ALU:
//   - ALU control codes (4-bit)
//   - scheduler FSM state encoding
//   - 64-bit operand and 128-bit result types
//   - small helper functions for opcode classification and latency lookup
// -----------------------------------------------------------------------------
package alu_op_scheduler_pkg;

  // ALU control codes
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_DIV = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  localparam int DATA_W   = 64;
  localparam int RESULT_W = 128;

  typedef logic [DATA_W-1:0]   alu_data_t;
  typedef logic [RESULT_W-1:0] alu_result_t;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } sched_state_t;

  // True for the opcodes the shared ALU implements.
  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    case (op)
      OP_AND, OP_DIV, OP_ADD, OP_MUL, OP_SUB, OP_SLT: legal = 1'b1;
      default:                                        legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Only ADD and SUB report a meaningful signed overflow.
  function automatic logic has_overflow(input logic [3:0] op);
    logic ovf;
    case (op)
      OP_ADD, OP_SUB: ovf = 1'b1;
      default:        ovf = 1'b0;
    endcase
    return ovf;
  endfunction

  // Number of cycles the operands must be held on the ALU before the
  // result may be captured.
  function automatic logic [3:0] op_latency(input logic [3:0] op,
                                            input logic [3:0] mul_lat,
                                            input logic [3:0] div_lat);
    logic [3:0] lat;
    case (op)
      OP_MUL:  lat = mul_lat;
      OP_DIV:  lat = div_lat;
      default: lat = 4'd1;
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/alu_op_scheduler_arbiter.sv
// -----------------------------------------------------------------------------
// alu_rr_arbiter
// Two-port round-robin grant with a last-granted pointer.
//   clk, reset   : clock, asynchronous active-high reset
//   enable       : grants may only be issued while enable is high
//   req0, req1   : request from port 0 / port 1
//   gnt0, gnt1   : one-hot (or zero) grant, combinational from inputs and
//                  the registered pointer
// The pointer holds the index of the last granted port. It resets to 1 so
// port 0 wins the first tie, and it only moves when a grant is issued.
// -----------------------------------------------------------------------------
module alu_rr_arbiter (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic last_grant;

  // On a tie the port that was not granted last time wins; a lone
  // requester always wins.
  assign gnt0 = enable & req0 & (~req1 | last_grant);
  assign gnt1 = enable & req1 & (~req0 | ~last_grant);

  // Last-granted pointer, updated only when a grant is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (gnt0) begin
      last_grant <= 1'b0;
    end else if (gnt1) begin
      last_grant <= 1'b1;
    end else begin
      last_grant <= last_grant;
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// -----------------------------------------------------------------------------
// alu_op_scheduler
// Schedules requests from two ports onto one shared multi-cycle ALU and
// returns a single response per request.
//
// Parameters
//   MUL_LAT, DIV_LAT : ALU settle cycles for MUL / DIV (1..15)
// Ports
//   clk, reset                 : clock, asynchronous active-high reset
//   p0_* / p1_*                : request ports (valid/ready, op, a, b)
//   alu_a, alu_b, alu_ctrl     : registered operands/opcode to the ALU
//   alu_cin                    : ALU carry-in, tied low
//   alu_result, alu_zero,
//   alu_overflow               : ALU outputs, sampled on the last EXEC cycle
//   rsp_valid / rsp_ready      : response handshake
//   rsp_id                     : port that issued the request
//   rsp_result, rsp_zero,
//   rsp_overflow, rsp_err      : registered response payload
//
// Flow: IDLE accepts one request per cycle through the round-robin
// arbiter. Legal operations go to EXEC for their latency; DIV by zero and
// unknown opcodes skip EXEC and produce an error response directly. RESP
// holds the payload until the consumer takes it.
// -----------------------------------------------------------------------------
module alu_op_scheduler
  import alu_op_scheduler_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic [3:0]  p0_op,
  input  logic [63:0] p0_a,
  input  logic [63:0] p0_b,

  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic [3:0]  p1_op,
  input  logic [63:0] p1_a,
  input  logic [63:0] p1_b,

  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic [3:0]  alu_ctrl,
  output logic        alu_cin,
  input  alu_result_t alu_result,
  input  logic        alu_zero,
  input  logic        alu_overflow,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output alu_result_t rsp_result,
  output logic        rsp_zero,
  output logic        rsp_overflow,
  output logic        rsp_err
);

  localparam logic [3:0] MUL_CYC = 4'(MUL_LAT);
  localparam logic [3:0] DIV_CYC = 4'(DIV_LAT);

  sched_state_t state;
  logic         idle;      // registered "may accept" flag, low during reset
  logic [3:0]   cnt;       // remaining EXEC cycles minus one

  logic         gnt0;
  logic         gnt1;
  logic         accept;
  logic         sel_id;
  logic [3:0]   sel_op;
  logic [63:0]  sel_a;
  logic [63:0]  sel_b;
  logic         sel_illegal;
  logic         sel_div_zero;

  assign alu_cin = 1'b0;

  alu_rr_arbiter u_arb (
    .clk    (clk),
    .reset  (reset),
    .enable (idle),
    .req0   (p0_valid),
    .req1   (p1_valid),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  // A port is ready exactly when it holds the grant, so at most one
  // request can complete its handshake per cycle.
  assign p0_ready = gnt0;
  assign p1_ready = gnt1;
  assign accept   = gnt0 | gnt1;

  // Select the granted port's request and classify it for bypass.
  always_comb begin
    if (gnt1) begin
      sel_id = 1'b1;
      sel_op = p1_op;
      sel_a  = p1_a;
      sel_b  = p1_b;
    end else begin
      sel_id = 1'b0;
      sel_op = p0_op;
      sel_a  = p0_a;
      sel_b  = p0_b;
    end
    sel_illegal  = ~is_legal_op(sel_op);
    sel_div_zero = (sel_op == OP_DIV) && (sel_b == 64'd0);
  end

  // Scheduler FSM with registered ALU drive and response payload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      idle         <= 1'b0;
      cnt          <= 4'd0;
      alu_a        <= 64'd0;
      alu_b        <= 64'd0;
      alu_ctrl     <= 4'b0000;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= 128'd0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_a    <= sel_a;
            alu_b    <= sel_b;
            alu_ctrl <= sel_op;
            rsp_id   <= sel_id;
            idle     <= 1'b0;
            if (sel_illegal) begin
              // Unknown opcode: answer immediately with a zero result.
              state        <= ST_RESP;
              rsp_valid    <= 1'b1;
              rsp_result   <= 128'd0;
              rsp_zero     <= 1'b1;
              rsp_overflow <= 1'b0;
              rsp_err      <= 1'b1;
            end else if (sel_div_zero) begin
              // Divide by zero: never reaches the ALU, saturated result.
              state        <= ST_RESP;
              rsp_valid    <= 1'b1;
              rsp_result   <= {128{1'b1}};
              rsp_zero     <= 1'b0;
              rsp_overflow <= 1'b0;
              rsp_err      <= 1'b1;
            end else begin
              state <= ST_EXEC;
              cnt   <= op_latency(sel_op, MUL_CYC, DIV_CYC) - 4'd1;
            end
          end else begin
            idle <= 1'b1;
          end
        end

        ST_EXEC: begin
          if (cnt == 4'd0) begin
            // Last settle cycle: the ALU output is valid now.
            state        <= ST_RESP;
            rsp_valid    <= 1'b1;
            rsp_result   <= alu_result;
            rsp_zero     <= alu_zero;
            rsp_overflow <= has_overflow(alu_ctrl) ? alu_overflow : 1'b0;
            rsp_err      <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            idle      <= 1'b1;
          end else begin
            state <= ST_RESP;
          end
        end

        default: begin
          state     <= ST_IDLE;
          idle      <= 1'b0;
          rsp_valid <= 1'b0;
          cnt       <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// -----------------------------------------------------------------------------
// tb_alu_op_scheduler
// Self-checking bench for alu_op_scheduler. Contains a behavioural model of
// the shared ALU that only presents a correct result once its inputs have
// been held for the operation's settle time, plus a transaction-level
// reference for grant order, latency and response payload.
// -----------------------------------------------------------------------------
module tb_alu_op_scheduler;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 8;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_DIV = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_MUL = 4'b0011;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;

  typedef struct packed {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
  } req_t;

  typedef struct packed {
    logic [127:0] res;
    logic         ovf;
  } alu_out_t;

  typedef struct packed {
    logic [127:0] res;
    logic         zero;
    logic         ovf;
    logic         err;
  } rsp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         p0_valid, p1_valid;
  logic         p0_ready, p1_ready;
  logic [3:0]   p0_op, p1_op;
  logic [63:0]  p0_a, p0_b, p1_a, p1_b;
  logic [63:0]  alu_a, alu_b;
  logic [3:0]   alu_ctrl;
  logic         alu_cin;
  logic [127:0] alu_result;
  logic         alu_zero, alu_overflow;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [127:0] rsp_result;
  logic         rsp_zero, rsp_overflow, rsp_err;

  int total = 0;
  int bad   = 0;
  int model_last = 1;

  always #5 clk = ~clk;

  alu_op_scheduler #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_op(p0_op), .p0_a(p0_a), .p0_b(p0_b),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_op(p1_op), .p1_a(p1_a), .p1_b(p1_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
    .rsp_err(rsp_err)
  );

  // ---------------- reference arithmetic ----------------
  function automatic logic is_legal(input logic [3:0] op);
    return (op == C_AND) || (op == C_DIV) || (op == C_ADD) ||
           (op == C_MUL) || (op == C_SUB) || (op == C_SLT);
  endfunction

  function automatic alu_out_t ref_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    alu_out_t o;
    logic signed [127:0] ax, bx;
    logic [63:0] s;
    ax = {{64{a[63]}}, a};
    bx = {{64{b[63]}}, b};
    o.res = 128'd0;
    o.ovf = a[63] ^ b[63];
    case (op)
      C_AND: begin s = a & b; o.res = {{64{s[63]}}, s}; end
      C_ADD: begin s = a + b; o.res = {{64{s[63]}}, s}; o.ovf = (a[63] == b[63]) && (s[63] != a[63]); end
      C_SUB: begin s = a - b; o.res = {{64{s[63]}}, s}; o.ovf = (a[63] != b[63]) && (s[63] != a[63]); end
      C_MUL: o.res = ax * bx;
      C_DIV: o.res = (b == 64'd0) ? 128'd0 : ax / bx;
      C_SLT: o.res = ($signed(a) < $signed(b)) ? 128'd1 : 128'd0;
      default: o.res = 128'd0;
    endcase
    return o;
  endfunction

  function automatic rsp_t ref_rsp(input req_t r);
    rsp_t e;
    alu_out_t o;
    if (!is_legal(r.op)) begin
      e = '{res: 128'd0, zero: 1'b1, ovf: 1'b0, err: 1'b1};
    end else if (r.op == C_DIV && r.b == 64'd0) begin
      e = '{res: {128{1'b1}}, zero: 1'b0, ovf: 1'b0, err: 1'b1};
    end else begin
      o = ref_alu(r.op, r.a, r.b);
      e.res  = o.res;
      e.zero = (o.res == 128'd0);
      e.ovf  = (r.op == C_ADD || r.op == C_SUB) ? o.ovf : 1'b0;
      e.err  = 1'b0;
    end
    return e;
  endfunction

  // Cycles from accepting edge to first cycle with rsp_valid visible.
  function automatic int ref_lat(input req_t r);
    if (!is_legal(r.op) || (r.op == C_DIV && r.b == 64'd0)) return 1;
    if (r.op == C_MUL) return 1 + MUL_LAT;
    if (r.op == C_DIV) return 1 + DIV_LAT;
    return 2;
  endfunction

  // ---------------- shared ALU model with settle time ----------------
  logic acc_pending;
  int   settle;
  alu_out_t alu_true;
  int   need;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) acc_pending <= 1'b0;
    else       acc_pending <= (p0_valid && p0_ready) || (p1_valid && p1_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            settle <= 0;
    else if (acc_pending) settle <= 0;
    else if (settle < 1000) settle <= settle + 1;
  end

  // Result is deliberately corrupted until the operands have been held long enough.
  always_comb begin
    alu_true = ref_alu(alu_ctrl, alu_a, alu_b);
    need = (alu_ctrl == C_MUL) ? MUL_LAT : (alu_ctrl == C_DIV) ? DIV_LAT : 1;
    if (settle >= need - 1) begin
      alu_result   = alu_true.res;
      alu_zero     = (alu_true.res == 128'd0);
      alu_overflow = alu_true.ovf;
    end else begin
      alu_result   = ~alu_true.res;
      alu_zero     = (alu_true.res != 128'd0);
      alu_overflow = ~alu_true.ovf;
    end
  end

  // ---------------- drive helpers (no checking) ----------------
  task automatic apply_reset();
    @(posedge clk); #2 reset = 1'b1;
    #6 reset = 1'b0;
    @(posedge clk); #1;
    model_last = 1;
  endtask

  // Entered at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue2(input bit v0, input bit v1, input req_t r0, input req_t r1, output int gport);
    p0_valid = v0; p0_op = r0.op; p0_a = r0.a; p0_b = r0.b;
    p1_valid = v1; p1_op = r1.op; p1_a = r1.a; p1_b = r1.b;
    gport = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (p0_valid && p0_ready) gport = 0;
      else if (p1_valid && p1_ready) gport = 1;
      if (gport >= 0) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    p0_valid = 1'b0; p1_valid = 1'b0;
  endtask

  // Entered at posedge+1 after accept; returns at the negedge rsp_valid is seen.
  task automatic wait_rsp(output int lat, output bit ok);
    lat = 1; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic retire();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; rsp_ready = 1'b0;
    p0_valid = 1'b1; p1_valid = 1'b1;
    p0_op = C_ADD; p1_op = C_ADD; p0_a = 64'd1; p0_b = 64'd1; p1_a = 64'd2; p1_b = 64'd2;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({p0_ready, p1_ready, rsp_valid, rsp_id, rsp_zero, rsp_overflow, rsp_err, alu_cin} !== 8'd0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000000",
        {p0_ready, p1_ready, rsp_valid, rsp_id, rsp_zero, rsp_overflow, rsp_err, alu_cin});
    end
    total++;
    if ({alu_a, alu_b, alu_ctrl, rsp_result} !== {64'd0, 64'd0, 4'd0, 128'd0}) begin
      bad++; $display("FAIL reset_data: got a=%h b=%h ctrl=%h res=%h want zeros", alu_a, alu_b, alu_ctrl, rsp_result);
    end
    p0_valid = 1'b0; p1_valid = 1'b0;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    model_last = 1;
  endtask

  task automatic test_add_basic();
    req_t r; int g;
    r = '{op: C_ADD, a: 64'd5, b: 64'd7};
    issue2(1'b1, 1'b0, r, r, g);
    model_last = 0;
    total++;
    if (g !== 0) begin bad++; $display("FAIL add_grant: got %0d want 0", g); end
    @(negedge clk);
    total++;
    if ({alu_ctrl, alu_a, alu_b, rsp_valid} !== {C_ADD, 64'd5, 64'd7, 1'b0}) begin
      bad++; $display("FAIL add_exec: got ctrl=%b a=%0d b=%0d v=%b want 0010 5 7 0", alu_ctrl, alu_a, alu_b, rsp_valid);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if ({rsp_valid, rsp_id, rsp_zero, rsp_err, rsp_result} !== {1'b1, 1'b0, 1'b0, 1'b0, 128'd12}) begin
      bad++; $display("FAIL add_rsp: got v=%b id=%b z=%b e=%b res=%0d want 1 0 0 0 12",
        rsp_valid, rsp_id, rsp_zero, rsp_err, rsp_result);
    end
    retire();
  endtask

  task automatic test_round_robin();
    req_t r0, r1; int g, lat; bit ok; rsp_t e;
    apply_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      r0 = '{op: C_ADD, a: 64'(k), b: 64'd100};
      r1 = '{op: C_SUB, a: 64'd1000, b: 64'(k)};
      issue2(1'b1, 1'b1, r0, r1, g);
      total++;
      if (g !== (k % 2)) begin bad++; $display("FAIL rr_grant%0d: got %0d want %0d", k, g, k % 2); end
      e = ref_rsp((k % 2) ? r1 : r0);
      wait_rsp(lat, ok);
      total++;
      if (!ok || rsp_id !== 1'((k % 2)) || rsp_result !== e.res) begin
        bad++; $display("FAIL rr_rsp%0d: got ok=%b id=%b res=%0d want 1 %0d %0d", k, ok, rsp_id, rsp_result, k % 2, e.res);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;
    model_last = 1;
  endtask

  task automatic test_mul();
    req_t r; int g, lat; bit got;
    r = '{op: C_MUL, a: -64'sd3, b: 64'd4};
    issue2(1'b0, 1'b1, r, r, g);
    model_last = 1;
    total++;
    if (g !== 1) begin bad++; $display("FAIL mul_grant: got %0d want 1", g); end
    lat = 1; got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1'b1; break; end
      total++;
      if ({alu_ctrl, alu_a, alu_b} !== {C_MUL, r.a, r.b}) begin
        bad++; $display("FAIL mul_hold: got ctrl=%b a=%h b=%h want 0011 %h %h", alu_ctrl, alu_a, alu_b, r.a, r.b);
      end
      @(posedge clk);
      lat++;
    end
    total++;
    if (!got || lat != 1 + MUL_LAT) begin bad++; $display("FAIL mul_lat: got %0d want %0d", lat, 1 + MUL_LAT); end
    total++;
    if ({rsp_result, rsp_id, rsp_overflow, rsp_err} !== {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF4, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL mul_rsp: got res=%h id=%b ovf=%b err=%b want ...fff4 1 0 0", rsp_result, rsp_id, rsp_overflow, rsp_err);
    end
    retire();
  endtask

  task automatic test_bypass();
    req_t r; int g, lat; bit ok;
    r = '{op: C_DIV, a: 64'd10, b: 64'd0};
    issue2(1'b1, 1'b0, r, r, g);
    model_last = 0;
    wait_rsp(lat, ok);
    total++;
    if (!ok || lat != 1) begin bad++; $display("FAIL div0_lat: got %0d want 1", lat); end
    total++;
    if ({rsp_result, rsp_err, rsp_zero, rsp_overflow, rsp_id} !== {{128{1'b1}}, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL div0_rsp: got res=%h e=%b z=%b o=%b id=%b", rsp_result, rsp_err, rsp_zero, rsp_overflow, rsp_id);
    end
    retire();
    r = '{op: 4'b1010, a: 64'd3, b: 64'd4};
    issue2(1'b0, 1'b1, r, r, g);
    model_last = 1;
    wait_rsp(lat, ok);
    total++;
    if (!ok || lat != 1) begin bad++; $display("FAIL ill_lat: got %0d want 1", lat); end
    total++;
    if ({rsp_result, rsp_err, rsp_zero, rsp_id} !== {128'd0, 1'b1, 1'b1, 1'b1}) begin
      bad++; $display("FAIL ill_rsp: got res=%h e=%b z=%b id=%b want 0 1 1 1", rsp_result, rsp_err, rsp_zero, rsp_id);
    end
    retire();
  endtask

  task automatic test_backpressure();
    req_t r; int g, lat; bit ok;
    r = '{op: C_SUB, a: 64'd20, b: 64'd5};
    issue2(1'b1, 1'b0, r, r, g);
    model_last = 0;
    wait_rsp(lat, ok);
    total++;
    if (!ok || lat != 2) begin bad++; $display("FAIL bp_lat: got %0d want 2", lat); end
    p0_valid = 1'b1; p0_op = C_ADD; p1_valid = 1'b1; p1_op = C_AND;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if ({rsp_valid, rsp_result, rsp_id, p0_ready, p1_ready} !== {1'b1, 128'd15, 1'b0, 1'b0, 1'b0}) begin
        bad++; $display("FAIL bp_hold%0d: got v=%b res=%0d id=%b rdy=%b%b want 1 15 0 00",
          i, rsp_valid, rsp_result, rsp_id, p0_ready, p1_ready);
      end
    end
    p0_valid = 1'b0; p1_valid = 1'b0;
    retire();
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_retire: got %b want 0", rsp_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_exec();
    req_t r; int g, seen;
    r = '{op: C_DIV, a: 64'd100, b: 64'd7};
    issue2(1'b0, 1'b1, r, r, g);
    @(posedge clk); @(posedge clk);
    #3 reset = 1'b1; p0_valid = 1'b1;
    #1;
    total++;
    if ({alu_a, alu_b, alu_ctrl, rsp_valid, rsp_id, p0_ready, p1_ready, rsp_err, rsp_result} !==
        {64'd0, 64'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 128'd0}) begin
      bad++; $display("FAIL midrst_vals: got a=%h b=%h ctrl=%b v=%b id=%b rdy=%b%b want zeros",
        alu_a, alu_b, alu_ctrl, rsp_valid, rsp_id, p0_ready, p1_ready);
    end
    p0_valid = 1'b0;
    #2 reset = 1'b0;
    model_last = 1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL midrst_norsp: got %0d want 0", seen); end
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] rand_operand();
    int sel, t;
    sel = $urandom_range(0, 3);
    t = $urandom_range(0, 3);
    case (sel)
      0: return 64'(t - 1);
      1: return (t[0]) ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic req_t rand_req();
    req_t r; int k; logic [3:0] ops [6];
    ops = '{C_AND, C_DIV, C_ADD, C_MUL, C_SUB, C_SLT};
    k = $urandom_range(0, 7);
    if (k < 6) begin
      r.op = ops[k];
    end else begin
      r.op = 4'($urandom_range(8, 15));
    end
    r.a = rand_operand();
    r.b = rand_operand();
    return r;
  endfunction

  task automatic test_random();
    req_t r0, r1, rq; int mode, g, exp_port, lat, d; bit v0, v1, ok; rsp_t e;
    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 2);
      r0 = rand_req(); r1 = rand_req();
      v0 = (mode != 1); v1 = (mode != 0);
      exp_port = (v0 && v1) ? ((model_last == 1) ? 0 : 1) : (v0 ? 0 : 1);
      issue2(v0, v1, r0, r1, g);
      total++;
      if (g !== exp_port) begin bad++; $display("FAIL rnd_grant%0d: got %0d want %0d", n, g, exp_port); end
      model_last = exp_port;
      rq = (exp_port == 1) ? r1 : r0;
      e = ref_rsp(rq);
      wait_rsp(lat, ok);
      total++;
      if (!ok || lat != ref_lat(rq)) begin
        bad++; $display("FAIL rnd_lat%0d: op=%b got %0d want %0d", n, rq.op, lat, ref_lat(rq));
      end
      d = $urandom_range(0, 3);
      repeat (d) begin @(posedge clk); @(negedge clk); end
      total++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_err} !==
          {1'b1, 1'(exp_port), e.res, e.zero, e.ovf, e.err}) begin
        bad++; $display("FAIL rnd_rsp%0d: op=%b got v=%b id=%b res=%h z=%b o=%b e=%b want id=%0d res=%h z=%b o=%b e=%b",
          n, rq.op, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_err, exp_port, e.res, e.zero, e.ovf, e.err);
      end
      retire();
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_round_robin();
    test_mul();
    test_bypass();
    test_backpressure();
    test_random();
    test_reset_mid_exec();
    test_add_basic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
